// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, presents it to the MMU, and queues
// returned words (tagged with their PC) for decode; redirects flush the queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        HOLD,
  input  logic [31:0] MEM_DATA,
  input  logic        MEM_STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] PC,
  output logic        PC_CHANGED,
  output logic        IF_VALID,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  input  logic        IF_READY
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_FULL} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic          pc_changed_q;
  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   q_pc    [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          pop, push, redir;

  always_comb begin
    pop   = EN & (count_q != '0) & IF_READY;
    redir = EN & REDIRECT;
    push  = EN & ~HOLD & ~REDIRECT & ~MEM_STALL & ((count_q != FULL_CNT) | pop);

    count_d = count_q;
    if (redir)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);

    // State is derived from the same conditions as the datapath, never the reverse.
    state_d = state_q;
    if (EN) begin
      if (REDIRECT)
        state_d = S_RUN;
      else if (MEM_STALL)
        state_d = S_WAIT;
      else if (count_d == FULL_CNT)
        state_d = S_FULL;
      else
        state_d = S_RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      pc_changed_q <= 1'b1;
      count_q      <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (EN)
        pc_changed_q <= push | redir;
      if (redir) begin
        pc_q   <= REDIRECT_PC & 32'hFFFF_FFFC;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= MEM_DATA;
          q_pc[wr_ptr]    <= pc_q;
          wr_ptr          <= wr_ptr + AW'(1);
          pc_q            <= pc_q + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  assign PC         = pc_q;
  assign PC_CHANGED = pc_changed_q;
  assign IF_VALID   = (count_q != '0);
  assign IF_INSTR   = q_instr[rd_ptr];
  assign IF_PC      = q_pc[rd_ptr];

  a_full_state: assert property (@(posedge CLK) disable iff (RST)
    (state_q == S_FULL) |-> (count_q == FULL_CNT));

endmodule
